cla_addsub_pipe: RTL and testbench

- Parametrised, two-stage pipelined carry-lookahead adder/subtractor. It is the successor to the fixed 16-bit combinational CLA.
- Supports any WIDTH that is a multiple of 4, four arithmetic modes, and status flags.
- Uses valid/ready handshakes on both sides with full backpressure and a throughput of one operation per cycle.
- Sits between an operand source (register file or sequencer) and a result consumer in the lab datapath.

---
 rtl/cla_pkg.sv | 23 ++
 rtl/cla4_lookahead.sv | 24 ++
 rtl/cla_addsub_pipe.sv | 158 +++++++++++++++
 tb/tb_cla_addsub_pipe.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder/subtractor.
package cla_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ADC = 2'b10;
  localparam logic [1:0] OP_SBB = 2'b11;

  localparam int unsigned GROUP_W = 4;

  // Borrow-in for SBB is ~cin, which after inverting B becomes a carry-in of cin.
  function automatic logic carry_in(logic [1:0] op, logic cin);
    logic c0;
    unique case (op)
      OP_ADD:  c0 = 1'b0;
      OP_SUB:  c0 = 1'b1;
      OP_ADC:  c0 = cin;
      default: c0 = cin;
    endcase
    return c0;
  endfunction

endpackage

// File: rtl/cla4_lookahead.sv
// 4-wide carry-lookahead unit: bit carries plus group generate/propagate.
module cla4_lookahead (
  input  logic [3:0] g_i,
  input  logic [3:0] p_i,
  input  logic       ci_i,
  output logic [3:0] c_o,
  output logic       gg_o,
  output logic       pg_o,
  output logic       co_o
);

  always_comb begin
    c_o[0] = ci_i;
    c_o[1] = g_i[0] | (p_i[0] & ci_i);
    c_o[2] = g_i[1] | (p_i[1] & g_i[0]) | (p_i[1] & p_i[0] & ci_i);
    c_o[3] = g_i[2] | (p_i[2] & g_i[1]) | (p_i[2] & p_i[1] & g_i[0])
           | (p_i[2] & p_i[1] & p_i[0] & ci_i);
    gg_o   = g_i[3] | (p_i[3] & g_i[2]) | (p_i[3] & p_i[2] & g_i[1])
           | (p_i[3] & p_i[2] & p_i[1] & g_i[0]);
    pg_o   = &p_i;
    co_o   = gg_o | (pg_o & ci_i);
  end

endmodule

// File: rtl/cla_addsub_pipe.sv
// Two-stage pipelined CLA adder/subtractor with valid/ready on both sides.
// S1 holds conditioned operands as g/p; S2 holds the result and flags.
module cla_addsub_pipe
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NumGrp = WIDTH / GROUP_W;
  localparam int unsigned NumBlk = (NumGrp + 3) / 4;

  if ((WIDTH % GROUP_W) != 0 || WIDTH < GROUP_W) begin : g_width_check
    $error("cla_addsub_pipe: WIDTH must be a multiple of 4 and at least 4");
  end

  logic             s1_en, s2_en;
  logic             s1_valid_q, s2_valid_q;
  logic [WIDTH-1:0] s1_g_q, s1_p_q;
  logic             s1_c0_q;
  logic [WIDTH-1:0] b_eff, g_d, p_d;
  logic             c0_d;
  logic [WIDTH-1:0] carry, sum_d;
  logic             cout_d, ovf_d, zero_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q, zero_q;

  assign s2_en    = !s2_valid_q || out_ready;
  assign s1_en    = !s1_valid_q || s2_en;
  assign in_ready = s1_en;

  always_comb begin
    b_eff = b ^ {WIDTH{op[0]}};
    g_d   = a & b_eff;
    p_d   = a ^ b_eff;
    c0_d  = carry_in(op, cin);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
    end else if (s1_en) begin
      s1_valid_q <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (s1_en && in_valid) begin
      s1_g_q  <= g_d;
      s1_p_q  <= p_d;
      s1_c0_q <= c0_d;
    end
  end

  // Level 1: one lookahead per 4-bit group; its carry-in comes from level 2.
  for (genvar j = 0; j < NumGrp; j++) begin : g_grp
    logic [3:0] c;
    logic       ci, gg, pg, co;
    logic       unused_co;

    assign ci        = g_blk[j / 4].c[j % 4];
    assign unused_co = co;

    cla4_lookahead u_la (
      .g_i  (s1_g_q[4*j +: 4]),
      .p_i  (s1_p_q[4*j +: 4]),
      .ci_i (ci),
      .c_o  (c),
      .gg_o (gg),
      .pg_o (pg),
      .co_o (co)
    );

    assign carry[4*j +: 4] = c;
  end

  // Level 2: lookahead across up to four groups per 16-bit block; blocks ripple.
  // Missing lanes of a partial block propagate (p=1, g=0) so co stays exact.
  for (genvar bk = 0; bk < NumBlk; bk++) begin : g_blk
    logic [3:0] gv, pv, c;
    logic       ci, gg, pg, co;
    logic       unused_gp;

    for (genvar k = 0; k < 4; k++) begin : g_lane
      if (bk * 4 + k < NumGrp) begin : g_real
        assign gv[k] = g_grp[bk*4 + k].gg;
        assign pv[k] = g_grp[bk*4 + k].pg;
      end else begin : g_pad
        assign gv[k] = 1'b0;
        assign pv[k] = 1'b1;
      end
    end

    if (bk == 0) begin : g_first
      assign ci = s1_c0_q;
    end else begin : g_chain
      assign ci = g_blk[bk-1].co;
    end

    assign unused_gp = gg ^ pg;

    cla4_lookahead u_la (
      .g_i  (gv),
      .p_i  (pv),
      .ci_i (ci),
      .c_o  (c),
      .gg_o (gg),
      .pg_o (pg),
      .co_o (co)
    );
  end

  always_comb begin
    sum_d  = s1_p_q ^ carry;
    cout_d = g_blk[NumBlk-1].co;
    ovf_d  = carry[WIDTH-1] ^ cout_d;
    zero_d = (sum_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
    end else if (s2_en) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Self-checking bench: directed vector table, stall/reset sequences, narrow widths,
// and a randomized handshake stream scored against an arithmetic model.
module tb_cla_addsub_pipe;
  import cla_pkg::*;

  typedef struct packed {
    logic [31:0] s;
    logic        co;
    logic        ov;
    logic        z;
  } res_t;

  typedef struct {
    string       nm;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    res_t        exp;
  } vec_t;

  localparam int NumRand = 10000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, sum;
  logic [1:0]  op;
  logic        cin, cout, ovf, zero;

  logic        n8_valid, n8_ready, n8_ovalid, n8_cin, n8_cout, n8_ovf, n8_zero;
  logic [7:0]  n8_a, n8_b, n8_sum;
  logic [1:0]  n8_op;
  logic        n20_valid, n20_ready, n20_ovalid, n20_cin, n20_cout, n20_ovf, n20_zero;
  logic [19:0] n20_a, n20_b, n20_sum;
  logic [1:0]  n20_op;

  int   n_checks = 0;
  int   n_fail   = 0;
  res_t sb_q[$];
  vec_t vecs[10];

  always #5 clk = ~clk;

  cla_addsub_pipe #(.WIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .op(op), .cin(cin), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf), .zero(zero)
  );

  cla_addsub_pipe #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(n8_valid), .in_ready(n8_ready), .a(n8_a), .b(n8_b),
    .op(n8_op), .cin(n8_cin), .out_valid(n8_ovalid), .out_ready(1'b1), .sum(n8_sum),
    .cout(n8_cout), .ovf(n8_ovf), .zero(n8_zero)
  );

  cla_addsub_pipe #(.WIDTH(20)) u_dut20 (
    .clk(clk), .rst(rst), .in_valid(n20_valid), .in_ready(n20_ready), .a(n20_a),
    .b(n20_b), .op(n20_op), .cin(n20_cin), .out_valid(n20_ovalid), .out_ready(1'b1),
    .sum(n20_sum), .cout(n20_cout), .ovf(n20_ovf), .zero(n20_zero)
  );

  // Plain two's-complement arithmetic on w-bit operands.
  function automatic res_t model(int w, logic [31:0] ma, logic [31:0] mb, logic [1:0] mop,
                                 logic mcin);
    logic [63:0] mask, am, bm, tot;
    logic        c0;
    res_t        r;
    mask = (64'd1 << w) - 64'd1;
    am   = {32'b0, ma} & mask;
    bm   = (mop[0] ? ~{32'b0, mb} : {32'b0, mb}) & mask;
    c0   = (mop == 2'b00) ? 1'b0 : (mop == 2'b01) ? 1'b1 : mcin;
    tot  = am + bm + {63'b0, c0};
    r.s  = 32'(tot & mask);
    r.co = tot[w];
    r.ov = (am[w-1] == bm[w-1]) && (tot[w-1] != am[w-1]);
    r.z  = (r.s == 32'd0);
    return r;
  endfunction

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic void check_res(string nm, res_t act, res_t exp);
    check({nm, " sum"}, act.s, exp.s);
    check({nm, " cout"}, {31'b0, act.co}, {31'b0, exp.co});
    check({nm, " ovf"}, {31'b0, act.ov}, {31'b0, exp.ov});
    check({nm, " zero"}, {31'b0, act.z}, {31'b0, exp.z});
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: outputs must leave in acceptance order, each matching the model.
  always @(negedge clk) begin
    res_t e;
    if (rst) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard: got unexpected beat sum=%h, expected none", sum);
        end else begin
          e = sb_q.pop_front();
          check_res("scoreboard", {sum, cout, ovf, zero}, e);
        end
      end
      if (in_valid && in_ready) sb_q.push_back(model(32, a, b, op, cin));
    end
  end

  task automatic apply_main(input vec_t v);
    step();
    in_valid = 1'b1; a = v.a; b = v.b; op = v.op; cin = v.cin; out_ready = 1'b1;
    #1;
    check({v.nm, " in_ready"}, {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    #1;
    check({v.nm, " valid@k+1"}, {31'b0, out_valid}, 32'd0);
    step();
    #1;
    check({v.nm, " valid@k+2"}, {31'b0, out_valid}, 32'd1);
    check_res(v.nm, {sum, cout, ovf, zero}, v.exp);
  endtask

  task automatic apply_narrow(input int w, input logic [1:0] top, input logic [31:0] ta,
                              input logic [31:0] tb, input logic tc, input res_t exp,
                              input string nm);
    step();
    if (w == 8) begin
      n8_valid = 1'b1; n8_a = ta[7:0]; n8_b = tb[7:0]; n8_op = top; n8_cin = tc;
    end else begin
      n20_valid = 1'b1; n20_a = ta[19:0]; n20_b = tb[19:0]; n20_op = top; n20_cin = tc;
    end
    #1;
    check({nm, " in_ready"}, {31'b0, (w == 8) ? n8_ready : n20_ready}, 32'd1);
    step();
    n8_valid = 1'b0; n20_valid = 1'b0;
    step();
    #1;
    if (w == 8) begin
      check({nm, " valid"}, {31'b0, n8_ovalid}, 32'd1);
      check_res(nm, {24'b0, n8_sum, n8_cout, n8_ovf, n8_zero}, exp);
    end else begin
      check({nm, " valid"}, {31'b0, n20_ovalid}, 32'd1);
      check_res(nm, {12'b0, n20_sum, n20_cout, n20_ovf, n20_zero}, exp);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t ra, rb, rc;
    vec_t w;
    logic acc;
    int   sent, cyc;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = OP_ADD; cin = 1'b0; out_ready = 1'b0;
    n8_valid = 1'b0; n8_a = '0; n8_b = '0; n8_op = OP_ADD; n8_cin = 1'b0;
    n20_valid = 1'b0; n20_a = '0; n20_b = '0; n20_op = OP_ADD; n20_cin = 1'b0;

    vecs[0] = '{"add wrap", OP_ADD, 32'hFFFF_FFFF, 32'h1, 1'b0, '{32'h0, 1'b1, 1'b0, 1'b1}};
    vecs[1] = '{"sub ovf", OP_SUB, 32'h8000_0000, 32'h1, 1'b0,
                '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0}};
    vecs[2] = '{"sub neg", OP_SUB, 32'h5, 32'h7, 1'b0, '{32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}};
    vecs[3] = '{"adc ovf", OP_ADC, 32'h7FFF_FFFF, 32'h0, 1'b1,
                '{32'h8000_0000, 1'b0, 1'b1, 1'b0}};
    vecs[4] = '{"sbb borrow", OP_SBB, 32'h10, 32'h10, 1'b0,
                '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0}};
    vecs[5] = '{"add blk", OP_ADD, 32'h0000_FFFF, 32'h1, 1'b0,
                '{32'h0001_0000, 1'b0, 1'b0, 1'b0}};
    vecs[6] = '{"add nocin", OP_ADD, 32'h1, 32'h1, 1'b1, '{32'h2, 1'b0, 1'b0, 1'b0}};
    vecs[7] = '{"sub zero", OP_SUB, 32'h3, 32'h3, 1'b0, '{32'h0, 1'b1, 1'b0, 1'b1}};
    vecs[8] = '{"sbb noborrow", OP_SBB, 32'h0, 32'h0, 1'b1, '{32'h0, 1'b1, 1'b0, 1'b1}};
    vecs[9] = '{"adc full", OP_ADC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1,
                '{32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0}};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("reset out_valid", {31'b0, out_valid}, 32'd0);
    check("reset in_ready", {31'b0, in_ready}, 32'd1);
    check("reset sum", sum, 32'd0);
    check("reset flags", {29'b0, cout, ovf, zero}, 32'd0);

    for (int i = 0; i < 10; i++) apply_main(vecs[i]);

    // Backpressure: A, B fill the pipe, C waits until the consumer opens up.
    ra = model(32, 32'd1, 32'd2, OP_ADD, 1'b0);
    rb = model(32, 32'd10, 32'd3, OP_SUB, 1'b0);
    rc = model(32, 32'h8000_0000, 32'h8000_0000, OP_ADD, 1'b0);
    step();
    in_valid = 1'b1; a = 32'd1; b = 32'd2; op = OP_ADD; out_ready = 1'b0;
    #1; check("bp c0 in_ready", {31'b0, in_ready}, 32'd1);
    step();
    a = 32'd10; b = 32'd3; op = OP_SUB;
    #1; check("bp c1 in_ready", {31'b0, in_ready}, 32'd1);
    check("bp c1 out_valid", {31'b0, out_valid}, 32'd0);
    step();
    a = 32'h8000_0000; b = 32'h8000_0000; op = OP_ADD;
    #1; check("bp c2 in_ready", {31'b0, in_ready}, 32'd0);
    check("bp c2 out_valid", {31'b0, out_valid}, 32'd1);
    check("bp c2 sum A", sum, ra.s);
    step();
    #1; check("bp c3 in_ready", {31'b0, in_ready}, 32'd0);
    check("bp c3 sum A held", sum, ra.s);
    step();
    out_ready = 1'b1;
    #1; check("bp c4 in_ready", {31'b0, in_ready}, 32'd1);
    check("bp c4 sum A", sum, ra.s);
    step();
    in_valid = 1'b0;
    #1; check("bp c5 out_valid", {31'b0, out_valid}, 32'd1);
    check("bp c5 sum B", sum, rb.s);
    step();
    #1; check("bp c6 out_valid", {31'b0, out_valid}, 32'd1);
    check_res("bp c6 C", {sum, cout, ovf, zero}, rc);
    step();
    #1; check("bp c7 out_valid", {31'b0, out_valid}, 32'd0);

    // Reset with both stages full; the beat shown during reset must vanish.
    step();
    in_valid = 1'b1; a = 32'h1234; b = 32'h1; op = OP_ADD; out_ready = 1'b0;
    step();
    a = 32'h55; b = 32'h5;
    step();
    in_valid = 1'b0;
    #1; check("rst full in_ready", {31'b0, in_ready}, 32'd0);
    step();
    rst = 1'b1; in_valid = 1'b1; a = 32'h77; b = 32'h1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("rst out_valid", {31'b0, out_valid}, 32'd0);
    check("rst in_ready", {31'b0, in_ready}, 32'd1);
    check("rst sum", sum, 32'd0);
    check("rst flags", {29'b0, cout, ovf, zero}, 32'd0);
    step();
    #1; check("rst beat dropped", {31'b0, out_valid}, 32'd0);
    w = '{"post-rst", OP_SUB, 32'h9, 32'h2, 1'b0, '{32'h7, 1'b1, 1'b0, 1'b0}};
    apply_main(w);

    // Narrow widths: group and block carry crossings.
    apply_narrow(8, OP_ADD, 32'h0F, 32'h01, 1'b0, '{32'h10, 1'b0, 1'b0, 1'b0}, "w8 0F+1");
    apply_narrow(8, OP_ADD, 32'hFF, 32'h01, 1'b0, '{32'h00, 1'b1, 1'b0, 1'b1}, "w8 FF+1");
    apply_narrow(8, OP_ADD, 32'h7F, 32'h01, 1'b0, '{32'h80, 1'b0, 1'b1, 1'b0}, "w8 7F+1");
    apply_narrow(8, OP_SUB, 32'h00, 32'h01, 1'b0, '{32'hFF, 1'b0, 1'b0, 1'b0}, "w8 0-1");
    apply_narrow(20, OP_ADD, 32'h0F, 32'h1, 1'b0, '{32'h10, 1'b0, 1'b0, 1'b0}, "w20 F+1");
    apply_narrow(20, OP_ADD, 32'hFFFF, 32'h1, 1'b0, '{32'h10000, 1'b0, 1'b0, 1'b0},
                 "w20 FFFF+1");
    apply_narrow(20, OP_ADD, 32'hFFFFF, 32'h1, 1'b0, '{32'h0, 1'b1, 1'b0, 1'b1},
                 "w20 FFFFF+1");
    apply_narrow(20, OP_SUB, 32'h80000, 32'h1, 1'b0, '{32'h7FFFF, 1'b1, 1'b1, 1'b0},
                 "w20 min-1");
    for (int i = 0; i < 100; i++) begin
      logic [31:0] ta, tb;
      logic [1:0]  top;
      logic        tc;
      ta = pick(); tb = pick(); top = 2'($urandom_range(0, 3)); tc = 1'($urandom());
      apply_narrow((i % 2 == 0) ? 8 : 20, top, ta, tb, tc,
                   model((i % 2 == 0) ? 8 : 20, ta, tb, top, tc), "narrow rand");
    end

    // Random stream with random valid/ready; operands held until accepted.
    step();
    sent = 0; cyc = 0; acc = 1'b0; in_valid = 1'b0;
    while (sent < NumRand && cyc < 80000) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        a = pick(); b = pick(); op = 2'($urandom_range(0, 3)); cin = 1'($urandom());
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = in_valid && in_ready;
      if (acc) sent++;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    if (sent < NumRand) begin
      n_checks++;
      n_fail++;
      $display("FAIL random budget: got %0d beats accepted, expected %0d", sent, NumRand);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 20 && (sb_q.size() != 0 || out_valid); i++) step();
    check("drain pending", sb_q.size(), 32'd0);
    check("drain out_valid", {31'b0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
